// File: rtl/loop_sequencer_pkg.sv
// Shared types and default sizing for the loop sequencer and its watchdog.
package loop_sequencer_pkg;

  localparam int unsigned CNT_W_DEF          = 4;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CHECK,
    DONE
  } loop_state_e;

endpackage

// File: rtl/loop_watchdog.sv
// Counts consecutive enabled cycles and flags the cycle that completes LIMIT of them.
// Used by loop_sequencer only when LOOP_SEQUENCER_TIMEOUT_EN is defined.
module loop_watchdog #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt_q;

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expire = enable && (cnt_q == W'(LIMIT - 1));

endmodule

// File: rtl/loop_sequencer.sv
// Do-while iteration sequencer: issues one body request per iteration, tests count < limit after each ack.
// Optional ISSUE-state watchdog enabled by defining LOOP_SEQUENCER_TIMEOUT_EN.
module loop_sequencer
  import loop_sequencer_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
`ifdef LOOP_SEQUENCER_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] limit,
  input  logic             abort,
  output logic             body_req,
  output logic [CNT_W-1:0] body_idx,
  input  logic             body_ack,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             timeout
);

  loop_state_e      state_q, state_d;
  logic [CNT_W-1:0] count_q, lim_q;
  logic             wd_expire;

`ifdef LOOP_SEQUENCER_TIMEOUT_EN
  logic wd_clear, wd_enable, timeout_q;

  // Abort is excluded here so it always wins over an expiry in the same cycle.
  assign wd_clear  = (state_q != ISSUE) && (state_d == ISSUE);
  assign wd_enable = (state_q == ISSUE) && !body_ack && !abort;

  loop_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expire (wd_expire)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) timeout_q <= 1'b0;
    else        timeout_q <= wd_expire;
  end

  assign timeout = timeout_q;
`else
  assign wd_expire = 1'b0;
  assign timeout   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      lim_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        lim_q   <= limit;
        count_q <= '0;
      end else if (state_q == ISSUE && body_ack && !abort) begin
        count_q <= count_q + 1'b1;
      end
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start) state_d = ISSUE;
      ISSUE: begin
        if (abort)          state_d = IDLE;
        else if (wd_expire) state_d = IDLE;
        else if (body_ack)  state_d = CHECK;
      end
      CHECK: begin
        if (abort)                 state_d = IDLE;
        else if (count_q < lim_q)  state_d = ISSUE;
        else                       state_d = DONE;
      end
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode only flops, so no input reaches an output combinationally.
  always_comb begin
    body_req = (state_q == ISSUE);
    body_idx = (state_q == ISSUE) ? count_q : '0;
    busy     = (state_q != IDLE);
    done     = (state_q == DONE);
  end

  assign count = count_q;

endmodule

// File: tb/tb_loop_sequencer.sv
// Directed self-checking bench for loop_sequencer; expected values are hand-derived cycle counts.
module tb_loop_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, start, abort, body_ack;
  logic [3:0] limit;
  logic       body_req, busy, done, timeout;
  logic [3:0] body_idx, count;

  int n_chk  = 0;
  int n_pass = 0;

  loop_sequencer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .limit    (limit),
    .abort    (abort),
    .body_req (body_req),
    .body_idx (body_idx),
    .body_ack (body_ack),
    .busy     (busy),
    .done     (done),
    .count    (count),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Raise start for the edge T0; the watcher's first negedge is then cycle c=0 after T0.
  task automatic launch(input logic [3:0] lim);
    @(negedge clk);
    start = 1'b1;
    limit = lim;
  endtask

  // Acks each request once it has been held for more than ack_delay cycles; optional abort
  // with the abort_iter-th ack and optional stray start at cycle restart_cyc.
  task automatic run_watch(input int max_cyc, input int ack_delay, input int abort_iter,
                           input int restart_cyc, output int n_req, output int done_cyc,
                           output int idle_cyc, output int idx_errs, output int max_run);
    int run, acks;
    logic [3:0] run_idx;
    n_req = 0; done_cyc = -1; idle_cyc = -1; idx_errs = 0; max_run = 0;
    run = 0; acks = 0; run_idx = '0;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      start    = (c == restart_cyc);
      if (c == restart_cyc) limit = 4'd2;
      abort    = 1'b0;
      body_ack = 1'b0;
      if (done && done_cyc < 0) done_cyc = c;
      if (!busy) begin
        idle_cyc = c;
        break;
      end
      if (body_req) begin
        if (run == 0) begin
          n_req++;
          run_idx = body_idx;
          if (body_idx != 4'(n_req - 1)) idx_errs++;
        end else if (body_idx != run_idx) begin
          idx_errs++;
        end
        run++;
        if (run > max_run) max_run = run;
        if (run > ack_delay) begin
          body_ack = 1'b1;
          acks++;
          if (acks == abort_iter) abort = 1'b1;
        end
      end else begin
        run = 0;
      end
    end
  endtask

  initial begin
    int n_req, done_cyc, idle_cyc, idx_errs, max_run, req_cyc, to_cyc, done_seen;

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; body_ack = 1'b0; limit = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_body_req", body_req, 0);
    check("rst_body_idx", body_idx, 0);
    check("rst_busy",     busy,     0);
    check("rst_done",     done,     0);
    check("rst_count",    count,    0);
    check("rst_timeout",  timeout,  0);
    rst_n = 1'b1;

    // limit=14, zero-wait ack: done at T0+28, idle at T0+29
    launch(4'd14);
    run_watch(60, 0, 0, -1, n_req, done_cyc, idle_cyc, idx_errs, max_run);
    check("l14_nreq",     n_req,    14);
    check("l14_idx_errs", idx_errs, 0);
    check("l14_done_cyc", done_cyc, 28);
    check("l14_idle_cyc", idle_cyc, 29);
    check("l14_count",    count,    14);

    // limit=0: do-while still runs one iteration
    launch(4'd0);
    run_watch(20, 0, 0, -1, n_req, done_cyc, idle_cyc, idx_errs, max_run);
    check("l0_nreq",     n_req,    1);
    check("l0_idx_errs", idx_errs, 0);
    check("l0_done_cyc", done_cyc, 2);
    check("l0_count",    count,    1);

    // limit=15: top of range, no wrap
    launch(4'd15);
    run_watch(60, 0, 0, -1, n_req, done_cyc, idle_cyc, idx_errs, max_run);
    check("l15_nreq",     n_req,    15);
    check("l15_done_cyc", done_cyc, 30);
    check("l15_count",    count,    15);

    // limit=3, ack after 3 wait cycles: each request held 4 cycles
    launch(4'd3);
    run_watch(60, 3, 0, -1, n_req, done_cyc, idle_cyc, idx_errs, max_run);
    check("slow_nreq",     n_req,    3);
    check("slow_max_run",  max_run,  4);
    check("slow_idx_errs", idx_errs, 0);
    check("slow_done_cyc", done_cyc, 15);
    check("slow_count",    count,    3);

    // limit=10, abort with the 5th ack: no done, count frozen at 4
    launch(4'd10);
    run_watch(60, 0, 5, -1, n_req, done_cyc, idle_cyc, idx_errs, max_run);
    check("abort_nreq",     n_req,    5);
    check("abort_done_cyc", done_cyc, -1);
    check("abort_idle_cyc", idle_cyc, 9);
    check("abort_count",    count,    4);

    // stray start with limit=2 during a limit=8 loop is ignored
    launch(4'd8);
    run_watch(60, 0, 0, 5, n_req, done_cyc, idle_cyc, idx_errs, max_run);
    check("restart_nreq",     n_req,    8);
    check("restart_done_cyc", done_cyc, 16);
    check("restart_count",    count,    8);

    // ack and abort while idle change nothing
    @(negedge clk);
    body_ack = 1'b1; abort = 1'b1;
    @(negedge clk);
    check("idle_ack_busy",  busy,  0);
    check("idle_ack_count", count, 8);
    body_ack = 1'b0; abort = 1'b0;

    // reset mid-loop
    launch(4'd8);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      start = 1'b0;
      body_ack = 1'b1;
    end
    @(negedge clk);
    check("prereset_req",   body_req, 1);
    check("prereset_count", count,    2);
    check("prereset_idx",   body_idx, 2);
    body_ack = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    check("midrst_outputs", {body_req, body_idx, busy, done, count, timeout}, 0);
    rst_n = 1'b1;

    // ack never arrives
    launch(4'd3);
    req_cyc = 0; to_cyc = -1; done_seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (body_req) req_cyc++;
      if (timeout && to_cyc < 0) to_cyc = c;
      if (done) done_seen++;
    end
`ifdef LOOP_SEQUENCER_TIMEOUT_EN
    check("wd_req_cycles", req_cyc, 16);
    check("wd_timeout_cyc", to_cyc, 16);
`else
    check("noack_req_cycles", req_cyc, 40);
    check("noack_timeout_cyc", to_cyc, -1);
`endif
    check("noack_done", done_seen, 0);
    check("noack_count", count, 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("noack_end_busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
